// File: rtl/calc_sequencer.sv
// Key-stream sequencer for the 4-bit calculator ALU: gathers A, op and B,
// holds the ALU inputs for SETTLE cycles, then latches the 7-segment result.
module calc_sequencer #(
  parameter int          SETTLE    = 2,
  parameter logic [6:0]  BLANK_SEG = 7'b0000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_valid,
  output logic       key_ready,
  input  logic [1:0] key_type,
  input  logic [3:0] key_val,
  output logic [3:0] alu_i1,
  output logic [3:0] alu_i2,
  output logic [1:0] alu_ctrl,
  input  logic [6:0] alu_o,
  output logic [6:0] disp_seg,
  output logic       busy,
  output logic       done,
  output logic       err
);

  typedef enum logic [2:0] {IDLE, GOT_A, GOT_OP, GOT_B, EXEC, SHOW} state_t;

  localparam logic [1:0] K_DIGIT = 2'b00;
  localparam logic [1:0] K_OP    = 2'b01;
  localparam logic [1:0] K_EQ    = 2'b10;
  localparam logic [1:0] K_CLR   = 2'b11;
  localparam logic [3:0] LAST    = 4'(SETTLE - 1);

  state_t     state, state_nx;
  logic [3:0] cnt, cnt_nx;
  logic [3:0] i1_nx, i2_nx;
  logic [1:0] ctrl_nx;
  logic [6:0] seg_nx;
  logic       done_nx, err_nx;
  logic       take;

  assign key_ready = (state != EXEC);
  assign busy      = (state == EXEC);
  assign take      = key_valid && key_ready;

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    i1_nx    = alu_i1;
    i2_nx    = alu_i2;
    ctrl_nx  = alu_ctrl;
    seg_nx   = disp_seg;
    done_nx  = 1'b0;
    err_nx   = 1'b0;
    if (state == EXEC) begin
      // The result is captured on the SETTLE-th edge after equals was taken.
      if (cnt == LAST) begin
        seg_nx   = alu_o;
        done_nx  = 1'b1;
        cnt_nx   = 4'd0;
        state_nx = SHOW;
      end else begin
        cnt_nx = cnt + 4'd1;
      end
    end else if (take) begin
      if (key_type == K_CLR) begin
        state_nx = IDLE;
        seg_nx   = BLANK_SEG;
        i1_nx    = 4'd0;
        i2_nx    = 4'd0;
        ctrl_nx  = 2'd0;
      end else begin
        case (state)
          IDLE, SHOW: begin
            if (key_type == K_DIGIT) begin
              i1_nx    = key_val;
              state_nx = GOT_A;
            end else begin
              err_nx = 1'b1;
            end
          end
          GOT_A: begin
            if (key_type == K_DIGIT) begin
              i1_nx = key_val;
            end else if (key_type == K_OP) begin
              ctrl_nx  = key_val[1:0];
              state_nx = GOT_OP;
            end else begin
              err_nx = 1'b1;
            end
          end
          GOT_OP: begin
            if (key_type == K_DIGIT) begin
              i2_nx    = key_val;
              state_nx = GOT_B;
            end else if (key_type == K_OP) begin
              ctrl_nx = key_val[1:0];
            end else begin
              err_nx = 1'b1;
            end
          end
          GOT_B: begin
            if (key_type == K_DIGIT) begin
              i2_nx = key_val;
            end else if (key_type == K_EQ) begin
              cnt_nx   = 4'd0;
              state_nx = EXEC;
            end else begin
              err_nx = 1'b1;
            end
          end
          default: state_nx = IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= 4'd0;
      alu_i1   <= 4'd0;
      alu_i2   <= 4'd0;
      alu_ctrl <= 2'd0;
      disp_seg <= BLANK_SEG;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      state    <= state_nx;
      cnt      <= cnt_nx;
      alu_i1   <= i1_nx;
      alu_i2   <= i2_nx;
      alu_ctrl <= ctrl_nx;
      disp_seg <= seg_nx;
      done     <= done_nx;
      err      <= err_nx;
    end
  end

endmodule

// File: tb/tb_calc_sequencer.sv
// Scoreboard bench for calc_sequencer: a key-rule model predicts err/done
// pulses and display contents; a negedge monitor checks what the DUT presents.
module tb_calc_sequencer;

  localparam int         SETTLE = 2;
  localparam logic [6:0] BLANK  = 7'b0000000;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       key_valid = 1'b0;
  logic [1:0] key_type = 2'd0;
  logic [3:0] key_val = 4'd0;
  logic       key_ready;
  logic [3:0] alu_i1, alu_i2;
  logic [1:0] alu_ctrl;
  logic [6:0] alu_o, disp_seg;
  logic       busy, done, err;

  typedef struct {
    bit         is_done;
    int         cyc;
    logic [6:0] seg;
  } ev_t;

  ev_t        q[$];
  ev_t        mon_ev;
  int         compared = 0;
  int         mismatched = 0;
  int         cyc = 0;
  bit         mon_en = 0;
  int         stage;
  logic [3:0] ma, mb;
  logic [1:0] mop;
  logic [6:0] exp_disp = BLANK;
  int         exec_start = 0;
  int         exec_end = 0;
  int         waits;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Stand-in ALU: any mixing function works, it only has to give 7'h5A for 3,4,op 00.
  function automatic logic [6:0] stub(input logic [3:0] a, input logic [3:0] b,
                                      input logic [1:0] c);
    return 7'h5A ^ {1'b0, c, a ^ 4'd3} ^ {b ^ 4'd4, 3'b000};
  endfunction

  assign alu_o = stub(alu_i1, alu_i2, alu_ctrl);

  calc_sequencer #(.SETTLE(SETTLE), .BLANK_SEG(BLANK)) dut (
    .clk(clk), .rst_n(rst_n), .key_valid(key_valid), .key_ready(key_ready),
    .key_type(key_type), .key_val(key_val), .alu_i1(alu_i1), .alu_i2(alu_i2),
    .alu_ctrl(alu_ctrl), .alu_o(alu_o), .disp_seg(disp_seg), .busy(busy),
    .done(done), .err(err)
  );

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] expv);
    compared++;
    if (act !== expv) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  function automatic void pushErr(input int e);
    ev_t x;
    x.is_done = 0; x.cyc = e; x.seg = 7'd0;
    q.push_back(x);
  endfunction

  // Key rules: stage 0 nothing held, 1 have A, 2 have op, 3 have B, 4 showing a result.
  function automatic void modelAccept(input logic [1:0] t, input logic [3:0] v,
                                      input int e);
    ev_t x;
    if (t == 2'b11) begin
      stage = 0; ma = 0; mb = 0; mop = 0; exp_disp = BLANK;
    end else if (t == 2'b00) begin
      if (stage == 0 || stage == 4) begin ma = v; stage = 1; end
      else if (stage == 1) ma = v;
      else begin mb = v; stage = 3; end
    end else if (t == 2'b01) begin
      if (stage == 1 || stage == 2) begin mop = v[1:0]; stage = 2; end
      else pushErr(e);
    end else begin
      if (stage == 3) begin
        x.is_done = 1; x.cyc = e + SETTLE; x.seg = stub(ma, mb, mop);
        q.push_back(x);
        exec_start = e; exec_end = e + SETTLE; stage = 4;
      end else pushErr(e);
    end
  endfunction

  // Called at a negedge; returns at the negedge after the key was taken.
  task automatic applyStimulus(input logic [1:0] t, input logic [3:0] v,
                               output int nwait);
    int e;
    nwait = 0;
    key_valid = 1'b1; key_type = t; key_val = v;
    while (!key_ready && nwait < 40) begin
      @(negedge clk);
      nwait++;
    end
    if (!key_ready) begin
      checkOutput("key_ready_timeout", {31'd0, key_ready}, 32'd1);
      key_valid = 1'b0;
      return;
    end
    e = cyc + 1;
    @(posedge clk);
    modelAccept(t, v, e);
    @(negedge clk);
    key_valid = 1'b0;
    checkOutput("alu_i1", {28'd0, alu_i1}, {28'd0, ma});
    checkOutput("alu_i2", {28'd0, alu_i2}, {28'd0, mb});
    checkOutput("alu_ctrl", {30'd0, alu_ctrl}, {30'd0, mop});
  endtask

  // Called at a negedge; holds rst_n low across n edges.
  task automatic doReset(input int n);
    int r;
    rst_n = 1'b0;
    r = cyc + n;
    repeat (n) @(posedge clk);
    stage = 0; ma = 0; mb = 0; mop = 0; exp_disp = BLANK;
    if (exec_end > r) exec_end = r;
    while (q.size() > 0 && q[$].cyc >= r) void'(q.pop_back());
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic checkResetValues();
    checkOutput("rst_disp_seg", {25'd0, disp_seg}, {25'd0, BLANK});
    checkOutput("rst_alu_i1", {28'd0, alu_i1}, 32'd0);
    checkOutput("rst_alu_i2", {28'd0, alu_i2}, 32'd0);
    checkOutput("rst_alu_ctrl", {30'd0, alu_ctrl}, 32'd0);
    checkOutput("rst_key_ready", {31'd0, key_ready}, 32'd1);
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (q.size() > 0 && q[0].cyc == cyc) begin
        mon_ev = q.pop_front();
        checkOutput("done_pulse", {31'd0, done}, {31'd0, mon_ev.is_done});
        checkOutput("err_pulse", {31'd0, err}, {31'd0, !mon_ev.is_done});
        if (mon_ev.is_done) begin
          checkOutput("result_seg", {25'd0, disp_seg}, {25'd0, mon_ev.seg});
          exp_disp = mon_ev.seg;
        end
      end else begin
        checkOutput("no_pulse", {30'd0, done, err}, 32'd0);
      end
      checkOutput("disp_seg", {25'd0, disp_seg}, {25'd0, exp_disp});
      checkOutput("busy", {31'd0, busy},
                  {31'd0, (cyc >= exec_start && cyc < exec_end)});
      checkOutput("key_ready", {31'd0, key_ready},
                  {31'd0, !(cyc >= exec_start && cyc < exec_end)});
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    @(negedge clk);
    doReset(3);
    mon_en = 1;
    repeat (5) @(negedge clk);
    checkResetValues();

    $display("[TB] basic 3 op00 4 =");
    applyStimulus(2'b00, 4'd3, waits);
    applyStimulus(2'b01, 4'd0, waits);
    applyStimulus(2'b00, 4'd4, waits);
    applyStimulus(2'b10, 4'd0, waits);
    repeat (SETTLE + 1) @(negedge clk);
    checkOutput("disp_5a", {25'd0, disp_seg}, 32'h5A);

    $display("[TB] out-of-sequence keys");
    applyStimulus(2'b11, 4'd0, waits);
    checkOutput("clear_blank", {25'd0, disp_seg}, {25'd0, BLANK});
    applyStimulus(2'b01, 4'd1, waits);
    applyStimulus(2'b00, 4'd7, waits);
    applyStimulus(2'b10, 4'd0, waits);
    checkOutput("seq_alu_i1", {28'd0, alu_i1}, 32'd7);
    checkOutput("seq_alu_ctrl", {30'd0, alu_ctrl}, 32'd0);

    $display("[TB] overwrite keys");
    applyStimulus(2'b11, 4'd0, waits);
    applyStimulus(2'b00, 4'd2, waits);
    applyStimulus(2'b00, 4'd9, waits);
    applyStimulus(2'b01, 4'd2, waits);
    applyStimulus(2'b01, 4'd3, waits);
    applyStimulus(2'b00, 4'd1, waits);
    applyStimulus(2'b10, 4'd0, waits);
    checkOutput("ow_alu_i1", {28'd0, alu_i1}, 32'd9);
    checkOutput("ow_alu_ctrl", {30'd0, alu_ctrl}, 32'd3);
    checkOutput("ow_alu_i2", {28'd0, alu_i2}, 32'd1);
    repeat (SETTLE + 1) @(negedge clk);

    $display("[TB] clear and reset mid-exec");
    applyStimulus(2'b11, 4'd0, waits);
    applyStimulus(2'b00, 4'd3, waits);
    applyStimulus(2'b01, 4'd0, waits);
    applyStimulus(2'b00, 4'd4, waits);
    applyStimulus(2'b10, 4'd0, waits);
    doReset(1);
    checkResetValues();
    repeat (SETTLE + 2) @(negedge clk);
    checkOutput("abort_disp", {25'd0, disp_seg}, {25'd0, BLANK});

    $display("[TB] key held through exec");
    applyStimulus(2'b00, 4'd5, waits);
    applyStimulus(2'b01, 4'd2, waits);
    applyStimulus(2'b00, 4'd8, waits);
    applyStimulus(2'b10, 4'd0, waits);
    applyStimulus(2'b00, 4'd6, waits);
    checkOutput("held_wait_cycles", waits, SETTLE);
    checkOutput("held_alu_i1", {28'd0, alu_i1}, 32'd6);
    applyStimulus(2'b01, 4'd1, waits);

    $display("[TB] random keys");
    for (int i = 0; i < 400; i++) begin
      int r;
      logic [1:0] t;
      r = $urandom_range(0, 9);
      t = (r < 5) ? 2'b00 : (r < 7) ? 2'b01 : (r < 9) ? 2'b10 : 2'b11;
      applyStimulus(t, 4'($urandom_range(0, 15)), waits);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (SETTLE + 4) @(negedge clk);
    checkOutput("queue_drained", q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
